// File: rtl/blit_pkg.sv
// blit_pkg: shared types and helpers for the blit address counter.
//   state_t  : controller states (IDLE, RUN)
//   DEF_AW   : default address width (multiple of 4)
//   DEF_LW   : default transfer-count width
//   sext8()  : sign-extends an 8-bit step to DEF_AW bits
package blit_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DEF_AW = 16;
   localparam int DEF_LW = 10;

   function automatic logic [DEF_AW-1:0] sext8(input logic [7:0] inc);
      return {{(DEF_AW-8){inc[7]}}, inc};
   endfunction

endpackage

// File: rtl/blit_addr_counter_if.sv
// blit_addr_counter_if: bus between the transfer controller and the counter.
//   LOAD_ADDR/ADDR_IN : address load request and value
//   START/LEN_IN      : begin a run of LEN_IN steps
//   STEP/INC          : advance one step by signed 8-bit INC
//   ADDR/COUNT        : current address and remaining steps
//   BUSY/DONE/WRAP    : run active, completion pulse, sticky wrap
// master = controller side, slave = counter side.
interface blit_addr_counter_if
   import blit_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int LW = DEF_LW
) ();

   logic          LOAD_ADDR;
   logic [AW-1:0] ADDR_IN;
   logic          START;
   logic [LW-1:0] LEN_IN;
   logic          STEP;
   logic [7:0]    INC;
   logic [AW-1:0] ADDR;
   logic [LW-1:0] COUNT;
   logic          BUSY;
   logic          DONE;
   logic          WRAP;

   modport master (
      output LOAD_ADDR, ADDR_IN, START, LEN_IN, STEP, INC,
      input  ADDR, COUNT, BUSY, DONE, WRAP
   );

   modport slave (
      input  LOAD_ADDR, ADDR_IN, START, LEN_IN, STEP, INC,
      output ADDR, COUNT, BUSY, DONE, WRAP
   );

endinterface

// File: rtl/blit_addr_counter_addr_adder.sv
// cla_nibble: 4-bit carry-lookahead adder cell.
//   a, b : operands   cin : carry in   s : sum   cout : carry out
module cla_nibble (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic [3:0] g, p, c;

   assign g = a & b;
   assign p = a ^ b;

   // All four internal carries are formed directly from g/p/cin so the
   // cell contributes two gate levels to the inter-nibble chain.
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
   assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);
   assign s    = p ^ c;

endmodule

// addr_adder: AW-bit combinational adder of AW/4 lookahead nibbles with the
// nibble carry rippling LSB to MSB.
//   X, Y : operands   CIN : carry in   Z : sum   COUT : carry out of top nibble
module addr_adder #(
   parameter int AW = 16
) (
   input  logic [AW-1:0] X,
   input  logic [AW-1:0] Y,
   input  logic          CIN,
   output logic [AW-1:0] Z,
   output logic          COUT
);

   localparam int NIB = AW / 4;

   logic [NIB:0] carry;

   assign carry[0] = CIN;

   for (genvar i = 0; i < NIB; i++) begin : g_nib
      cla_nibble u_nib (
         .a    (X[4*i +: 4]),
         .b    (Y[4*i +: 4]),
         .cin  (carry[i]),
         .s    (Z[4*i +: 4]),
         .cout (carry[i+1])
      );
   end

   assign COUT = carry[NIB];

endmodule

// File: rtl/blit_addr_counter.sv
// blit_addr_counter: registered address-stepping counter for block transfers.
//   MasterClock : sole clock, rising edge
//   RESET       : synchronous, active-high
//   bus         : slave side of blit_addr_counter_if (load/start/step in,
//                 ADDR/COUNT/BUSY/DONE/WRAP out)
// IDLE accepts LOAD_ADDR and START; RUN accepts STEP. Each step adds the
// sign-extended INC to ADDR and decrements COUNT; the last step returns to
// IDLE with a one-cycle DONE pulse.
module blit_addr_counter
   import blit_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int LW = DEF_LW
) (
   input  logic MasterClock,
   input  logic RESET,
   blit_addr_counter_if.slave bus
);

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q;
   logic [LW-1:0] count_q;
   logic          done_q;
   logic          wrap_q;

   logic [AW-1:0] inc_ext;
   logic [AW-1:0] addr_sum;
   logic          cout;
   logic          step_ok;
   logic          last_step;
   logic          start_ok;

   // Signed cast keeps the extension correct when AW differs from DEF_AW.
   assign inc_ext = AW'($signed(sext8(bus.INC)));

   addr_adder #(.AW(AW)) u_adder (
      .X    (addr_q),
      .Y    (inc_ext),
      .CIN  (1'b0),
      .Z    (addr_sum),
      .COUT (cout)
   );

   assign step_ok   = (state_q == RUN) && bus.STEP;
   assign last_step = step_ok && (count_q == LW'(1));
   assign start_ok  = (state_q == IDLE) && bus.START;

   // State register
   always_ff @(posedge MasterClock) begin
      if (RESET) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (bus.START && (bus.LEN_IN != '0)) state_d = RUN;
         RUN:  if (last_step)                       state_d = IDLE;
         default:                                   state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      bus.BUSY = (state_q == RUN);
   end

   // Datapath registers
   always_ff @(posedge MasterClock) begin
      if (RESET) begin
         addr_q  <= '0;
         count_q <= '0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state_q == IDLE) begin
            if (bus.LOAD_ADDR) addr_q <= bus.ADDR_IN;
            if (start_ok) begin
               wrap_q <= 1'b0;
               if (bus.LEN_IN != '0) count_q <= bus.LEN_IN;
               else                  done_q  <= 1'b1;
            end
         end else if (step_ok) begin
            addr_q  <= addr_sum;
            count_q <= count_q - LW'(1);
            // Carry out disagreeing with the step's sign means the address
            // crossed the 0 / 2^AW boundary in either direction.
            if (cout ^ bus.INC[7]) wrap_q <= 1'b1;
            if (last_step)         done_q <= 1'b1;
         end
      end
   end

   assign bus.ADDR  = addr_q;
   assign bus.COUNT = count_q;
   assign bus.DONE  = done_q;
   assign bus.WRAP  = wrap_q;

endmodule

// File: tb/tb_blit_addr_counter.sv
// tb_blit_addr_counter: directed plus random checks of blit_addr_counter
// against an arithmetic reference model (integer add, modulo 2^AW).
module tb_blit_addr_counter;

   localparam int AW  = 16;
   localparam int LW  = 10;
   localparam int MOD = 1 << AW;

   logic clk;
   logic rst;

   blit_addr_counter_if #(.AW(AW), .LW(LW)) bus ();

   blit_addr_counter #(.AW(AW), .LW(LW)) dut (
      .MasterClock (clk),
      .RESET       (rst),
      .bus         (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk;
   int n_fail;

   // reference model state
   int m_addr, m_count;
   bit m_busy, m_done, m_wrap;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_step();
      int s, d;
      bit nd;
      nd = 0;
      if (rst) begin
         m_addr = 0; m_count = 0; m_busy = 0; m_wrap = 0;
      end else if (!m_busy) begin
         if (bus.LOAD_ADDR) m_addr = int'(bus.ADDR_IN);
         if (bus.START) begin
            m_wrap = 0;
            if (bus.LEN_IN != 0) begin
               m_count = int'(bus.LEN_IN);
               m_busy  = 1;
            end else nd = 1;
         end
      end else if (bus.STEP) begin
         d = $signed(bus.INC);
         s = m_addr + d;
         if (s < 0 || s >= MOD) m_wrap = 1;
         m_addr  = ((s % MOD) + MOD) % MOD;
         m_count = m_count - 1;
         if (m_count == 0) begin
            m_busy = 0;
            nd     = 1;
         end
      end
      m_done = nd;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk("addr",  int'(bus.ADDR),  m_addr);
      chk("count", int'(bus.COUNT), m_count);
      chk("busy",  int'(bus.BUSY),  int'(m_busy));
      chk("done",  int'(bus.DONE),  int'(m_done));
      chk("wrap",  int'(bus.WRAP),  int'(m_wrap));
   endtask

   task automatic idle_in();
      bus.LOAD_ADDR = 0; bus.START = 0; bus.STEP = 0;
   endtask

   task automatic load_start(input int a, input int len);
      bus.LOAD_ADDR = 1; bus.ADDR_IN = AW'(a);
      bus.START = 1; bus.LEN_IN = LW'(len);
      tick();
      idle_in();
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      m_addr = 0; m_count = 0; m_busy = 0; m_done = 0; m_wrap = 0;
      rst = 1; idle_in(); bus.ADDR_IN = '0; bus.LEN_IN = '0; bus.INC = '0;
      #2;
      tick();
      chk("rst_addr", int'(bus.ADDR), 0);
      chk("rst_busy", int'(bus.BUSY), 0);
      rst = 0;

      // basic run: 0x1234 +4 x3
      load_start('h1234, 3);
      chk("run_busy", int'(bus.BUSY), 1);
      bus.STEP = 1; bus.INC = 8'd4;
      tick(); chk("s1_addr", int'(bus.ADDR), 'h1238); chk("s1_cnt", int'(bus.COUNT), 2);
      tick(); chk("s2_addr", int'(bus.ADDR), 'h123C); chk("s2_cnt", int'(bus.COUNT), 1);
      tick(); chk("s3_addr", int'(bus.ADDR), 'h1240); chk("s3_done", int'(bus.DONE), 1);
      chk("s3_busy", int'(bus.BUSY), 0); chk("s3_wrap", int'(bus.WRAP), 0);
      bus.STEP = 0; tick(); chk("done_once", int'(bus.DONE), 0);

      // positive wrap
      load_start('hFFFE, 2);
      bus.STEP = 1; bus.INC = 8'd1;
      tick(); chk("pw1_addr", int'(bus.ADDR), 'hFFFF); chk("pw1_wrap", int'(bus.WRAP), 0);
      tick(); chk("pw2_addr", int'(bus.ADDR), 0);      chk("pw2_wrap", int'(bus.WRAP), 1);
      bus.STEP = 0; tick(); tick(); chk("wrap_sticky", int'(bus.WRAP), 1);

      // negative borrow
      load_start('h0001, 2);
      chk("start_clr_wrap", int'(bus.WRAP), 0);
      bus.STEP = 1; bus.INC = 8'hFF;
      tick(); chk("nw1_addr", int'(bus.ADDR), 0);      chk("nw1_wrap", int'(bus.WRAP), 0);
      tick(); chk("nw2_addr", int'(bus.ADDR), 'hFFFF); chk("nw2_wrap", int'(bus.WRAP), 1);
      bus.STEP = 0;
      load_start('h0010, 1);
      bus.STEP = 1; bus.INC = 8'hF0;
      tick(); chk("m16_addr", int'(bus.ADDR), 0); chk("m16_wrap", int'(bus.WRAP), 0);
      bus.STEP = 0;

      // zero-length run
      bus.START = 1; bus.LEN_IN = '0;
      tick(); bus.START = 0;
      chk("z_done", int'(bus.DONE), 1); chk("z_busy", int'(bus.BUSY), 0);
      chk("z_addr", int'(bus.ADDR), 0);
      tick(); chk("z_done_clr", int'(bus.DONE), 0);

      // LOAD_ADDR ignored while running
      load_start('h0100, 2);
      bus.LOAD_ADDR = 1; bus.ADDR_IN = 'h5555; bus.STEP = 1; bus.INC = 8'd2;
      tick(); chk("ld_run_addr", int'(bus.ADDR), 'h0102);
      bus.LOAD_ADDR = 0;
      tick(); chk("ld_run_addr2", int'(bus.ADDR), 'h0104);
      bus.STEP = 0;

      // reset mid-run
      load_start('h0200, 5);
      bus.STEP = 1; bus.INC = 8'd8;
      tick(); bus.STEP = 0;
      rst = 1; tick(); rst = 0;
      chk("mr_addr", int'(bus.ADDR), 0); chk("mr_cnt", int'(bus.COUNT), 0);
      chk("mr_busy", int'(bus.BUSY), 0); chk("mr_done", int'(bus.DONE), 0);

      // START in the DONE cycle
      load_start('h0300, 1);
      bus.STEP = 1; bus.INC = 8'd1;
      tick(); chk("bb_done", int'(bus.DONE), 1);
      bus.STEP = 0; bus.START = 1; bus.LEN_IN = LW'(2);
      tick(); bus.START = 0;
      chk("bb_busy", int'(bus.BUSY), 1); chk("bb_cnt", int'(bus.COUNT), 2);
      bus.STEP = 1; bus.INC = 8'h81;
      tick(); tick();
      chk("bb_addr", int'(bus.ADDR), ('h0301 - 254 + MOD) % MOD);
      bus.STEP = 0;

      // random traffic
      for (int i = 0; i < 10000; i++) begin
         rst           = ($urandom_range(0, 999) == 0);
         bus.STEP      = ($urandom_range(0, 9) < 7);
         bus.INC       = 8'($urandom);
         bus.LOAD_ADDR = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 3))
            0:       bus.ADDR_IN = AW'($urandom_range(0, 300));
            1:       bus.ADDR_IN = AW'(MOD - 1 - $urandom_range(0, 300));
            default: bus.ADDR_IN = AW'($urandom);
         endcase
         bus.START  = ($urandom_range(0, 5) == 0);
         bus.LEN_IN = ($urandom_range(0, 9) == 0) ? '0 : LW'($urandom_range(1, 40));
         tick();
      end
      rst = 0; idle_in();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/blit_addr_counter.md
# blit_addr_counter

Registered address-stepping counter for block-transfer sequencing. Holds an AW-bit address and a LW-bit transfer count. On each accepted step it adds a sign-extended 8-bit increment to the address through a chain of 4-bit lookahead adder nibbles, and decrements the count. It signals completion and address wrap. It sits between the transfer controller (START/STEP) and the memory address mux (ADDR).

## Interface
- AW, 16: address width; must be a multiple of 4.
- LW, 10: transfer-count width.

- MasterClock  in  1  sole clock; all state changes on rising edge.
- RESET  in  1  reset, synchronous, active-high.
- LOAD_ADDR  in  1  load ADDR_IN into the address register (IDLE only).
- ADDR_IN  in  AW  address load value.
- START  in  1  begin a run of LEN_IN steps (IDLE only).
- LEN_IN  in  LW  step count for the run; 0 is legal.
- STEP  in  1  advance one step (RUN only).
- INC  in  8  signed two's-complement step, sign-extended to AW.
- ADDR  out  AW  current address (registered).
- COUNT  out  LW  remaining steps (registered).
- BUSY  out  1  high in RUN.
- DONE  out  1  one-cycle completion pulse.
- WRAP  out  1  sticky address wrap flag for the current run.

## Operation
- Reset values: ADDR=0, COUNT=0, BUSY=0, DONE=0, WRAP=0, state IDLE.
- States: IDLE, RUN.
- **IDLE**
  - LOAD_ADDR: ADDR<=ADDR_IN.
  - START with LEN_IN≠0: COUNT<=LEN_IN, WRAP<=0, go to RUN.
  - START with LEN_IN=0: WRAP<=0, DONE pulses next cycle, stay IDLE.
  - STEP is ignored.
- **LOAD_ADDR and START in the same cycle:** both take effect. The first step uses ADDR_IN.
- **RUN**
  - STEP: ADDR<=ADDR+sext(INC) mod 2^AW; COUNT<=COUNT-1.
  - Each step with COUT^INC[7]=1 sets WRAP. This covers unsigned overflow for positive INC and borrow for negative INC. INC=0 never sets WRAP.
  - STEP with COUNT=1: go to IDLE, DONE=1 for exactly one cycle, COUNT=0.
  - LOAD_ADDR and START are ignored.
  - STEP low: all state holds.
- **Adder:** carry-in is 0. The nibble carry ripples LSB to MSB. COUT is the carry out of the top nibble. The adder is purely combinational; only the address register is sequential.
- **Reset mid-run:** returns everything to reset values on that edge. No DONE pulse is produced.
- **Wrap-around:** the address wraps modulo 2^AW with no saturation. WRAP is cleared only by START or RESET.

## Timing
- Latency: every output updates on the edge that samples the causing input (1 cycle).
- BUSY rises the cycle after START and falls in the same cycle DONE rises.
- Back-to-back STEP every cycle is supported: one step per clock, no bubbles.
- START is accepted in the DONE cycle, because the state is already IDLE.
- Combinational path: ADDR → AW/4 nibble chain → register. This path must close at the MasterClock rate.

## Structure
- Package blit_pkg:
  - state enum {IDLE, RUN}.
  - Default AW/LW localparams.
  - Function sext8(INC) returning AW bits.
- Sub-module addr_adder:
  - AW-bit adder of AW/4 instances of the 4-bit lookahead adder nibble cell, carry-chained.
  - Ports: X[AW], Y[AW], CIN, Z[AW], COUT.
- Top level holds:
  - State register.
  - ADDR, COUNT, DONE and WRAP registers.
  - Count decrement, via a plain subtractor.

## Test plan
- Reset, LOAD_ADDR ADDR_IN=0x1234, START LEN_IN=3, INC=+4, STEP ×3 → ADDR 0x1238, 0x123C, 0x1240. COUNT 2,1,0. DONE one pulse after the third step. WRAP=0.
- ADDR=0xFFFE, LEN=2, INC=+1 → ADDR 0xFFFF then 0x0000. WRAP=1 after the second step and stays 1 until the next START.
- ADDR=0x0001, LEN=2, INC=-1 (0xFF) → ADDR 0x0000 (WRAP=0) then 0xFFFF (WRAP=1). Also ADDR=0x0010, INC=-16 → 0x0000 with WRAP=0.
- START LEN_IN=0 → DONE pulse next cycle, BUSY stays 0, ADDR unchanged. Also STEP/LOAD_ADDR during RUN → address changes only by INC, load ignored.
- RESET asserted after one of five steps → next cycle ADDR=0, COUNT=0, BUSY=0, no DONE. Then START in the DONE cycle of a fresh run → new run begins with no dead cycle.
- Random INC/LEN/STEP gaps for 10k cycles against a modulo-2^AW reference model → ADDR, COUNT, WRAP and DONE match every cycle.
